// File: rtl/hazard_ctrl_if.sv
// Purpose: bundles the pipeline-buffer fields consumed by hazard_ctrl and the
// enables/flushes/status it returns to the datapath.
// Ports (signals):
//   to controller  : ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
//                    idex_memread, idex_rd, idex_halt, ex_redirect, dmem_busy
//   from controller: pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                    exmem_en, memwb_en, halted, stall_cycles, flush_cycles
// Modports: master = datapath side, slave = hazard_ctrl side.
interface hazard_ctrl_if #(
  parameter int unsigned REG_AW = 5
);
  logic [REG_AW-1:0] ifid_rs1;
  logic [REG_AW-1:0] ifid_rs2;
  logic              ifid_use_rs1;
  logic              ifid_use_rs2;
  logic              idex_memread;
  logic [REG_AW-1:0] idex_rd;
  logic              idex_halt;
  logic              ex_redirect;
  logic              dmem_busy;

  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_en;
  logic              idex_flush;
  logic              exmem_en;
  logic              memwb_en;
  logic              halted;
  logic [31:0]       stall_cycles;
  logic [31:0]       flush_cycles;

  modport master (
    output ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           idex_memread, idex_rd, idex_halt, ex_redirect, dmem_busy,
    input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, halted, stall_cycles, flush_cycles
  );

  modport slave (
    input  ifid_rs1, ifid_rs2, ifid_use_rs1, ifid_use_rs2,
           idex_memread, idex_rd, idex_halt, ex_redirect, dmem_busy,
    output pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
           exmem_en, memwb_en, halted, stall_cycles, flush_cycles
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose: backward-flowing hazard control for the 5-stage pipeline. Detects
// load-use hazards, applies EX redirects, memory-busy freezes and HALT drain,
// producing same-cycle PC/buffer enables and flushes.
// Ports:
//   clk     : core clock
//   reset_n : synchronous active-low reset
//   hz      : hazard_ctrl_if.slave (buffer fields in, enables/flushes/status out)
// Optional feature: define HAZARD_PERF_CNT_EN to build saturating 32-bit
// stall/flush cycle counters; otherwise those outputs are tied to 0.
module hazard_ctrl #(
  parameter int unsigned REG_AW       = 5,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  hazard_ctrl_if.slave  hz
);

  localparam int unsigned DCW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [REG_AW-1:0] REG_X0 = '0;

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t         state, state_d;
  logic [DCW-1:0] dcnt, dcnt_d;
  logic           load_use;

  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
  logic exmem_en, memwb_en, halted;

  // x0 never carries a real dependency; unused operands never stall
  assign load_use = hz.idex_memread && (hz.idex_rd != REG_X0) &&
                    ((hz.ifid_use_rs1 && (hz.idex_rd == hz.ifid_rs1)) ||
                     (hz.ifid_use_rs2 && (hz.idex_rd == hz.ifid_rs2)));

  // State and drain counter
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= RUN;
      dcnt  <= '0;
    end else begin
      state <= state_d;
      dcnt  <= dcnt_d;
    end
  end

  // Next state and decoded enables/flushes; a flushed buffer always has en=1
  always_comb begin
    state_d    = state;
    dcnt_d     = dcnt;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b0;
    idex_en    = 1'b0;
    idex_flush = 1'b0;
    exmem_en   = 1'b0;
    memwb_en   = 1'b0;
    halted     = 1'b0;

    unique case (state)
      RUN: begin
        if (hz.dmem_busy) begin
          // full freeze: defaults already hold every buffer
        end else if (hz.ex_redirect) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else if (hz.idex_halt) begin
          state_d    = DRAIN;
          dcnt_d     = DCW'(DRAIN_CYCLES);
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else if (load_use) begin
          idex_en    = 1'b1;
          idex_flush = 1'b1;
          exmem_en   = 1'b1;
          memwb_en   = 1'b1;
        end else begin
          pc_en    = 1'b1;
          ifid_en  = 1'b1;
          idex_en  = 1'b1;
          exmem_en = 1'b1;
          memwb_en = 1'b1;
        end
      end
      DRAIN: begin
        ifid_en    = 1'b1;
        ifid_flush = 1'b1;
        idex_en    = 1'b1;
        idex_flush = 1'b1;
        exmem_en   = !hz.dmem_busy;
        memwb_en   = !hz.dmem_busy;
        if (!hz.dmem_busy) begin
          dcnt_d = dcnt - DCW'(1);
          if (dcnt == DCW'(1)) state_d = HALTED;
        end
      end
      HALTED: halted = 1'b1;
      default: state_d = RUN;
    endcase

    // Outputs held safe while reset is asserted
    if (!reset_n) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      exmem_en   = 1'b0;
      memwb_en   = 1'b0;
      halted     = 1'b0;
    end
  end

  assign hz.pc_en      = pc_en;
  assign hz.ifid_en    = ifid_en;
  assign hz.ifid_flush = ifid_flush;
  assign hz.idex_en    = idex_en;
  assign hz.idex_flush = idex_flush;
  assign hz.exmem_en   = exmem_en;
  assign hz.memwb_en   = memwb_en;
  assign hz.halted     = halted;

`ifdef HAZARD_PERF_CNT_EN
  logic        sel_stall, sel_flush;
  logic [31:0] stall_q, flush_q;

  // Selected RUN actions, mirroring the priority order above
  assign sel_flush = (state == RUN) && !hz.dmem_busy && hz.ex_redirect;
  assign sel_stall = (state == RUN) && !hz.dmem_busy && !hz.ex_redirect &&
                     !hz.idex_halt && load_use;

  // Saturating performance counters
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (sel_stall && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (sel_flush && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_cycles = flush_q;
`else
  assign hz.stall_cycles = '0;
  assign hz.flush_cycles = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Purpose: directed self-checking bench for hazard_ctrl: table-driven RUN
// vectors plus hand-written halt-drain, busy-drain and reset-in-drain sequences.
// Output vector bit order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
// exmem_en, memwb_en, halted}.
module tb_hazard_ctrl;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  localparam logic [7:0] O_RUN    = 8'b1101_0110;
  localparam logic [7:0] O_BUSY   = 8'b0000_0000;
  localparam logic [7:0] O_REDIR  = 8'b1111_1110;
  localparam logic [7:0] O_LU     = 8'b0001_1110;
  localparam logic [7:0] O_DRAIN  = 8'b0111_1110;
  localparam logic [7:0] O_DRAINB = 8'b0111_1000;
  localparam logic [7:0] O_HALTED = 8'b0000_0001;
  localparam logic [7:0] O_RESET  = 8'b0010_1000;

  logic clk;
  logic reset_n;

  hazard_ctrl_if #(.REG_AW(5)) bus ();

  hazard_ctrl #(.REG_AW(5), .DRAIN_CYCLES(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .hz      (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       use1;
    logic       use2;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       memread;
    logic [4:0] rd;
    logic       redir;
    logic       busy;
    logic [7:0] exp;
    int         stall_inc;
    int         flush_inc;
  } vec_t;

  vec_t        vecs[12];
  int          errors = 0;
  int          checks = 0;
  int unsigned exp_stall = 0;
  int unsigned exp_flush = 0;

  function automatic logic [7:0] outs();
    return {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_en,
            bus.idex_flush, bus.exmem_en, bus.memwb_en, bus.halted};
  endfunction

  function automatic logic [31:0] pexp(int unsigned v);
    return PERF_ON ? 32'(v) : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic chk_cnt(input string nm);
    chk({nm, " stall_cycles"}, bus.stall_cycles, pexp(exp_stall));
    chk({nm, " flush_cycles"}, bus.flush_cycles, pexp(exp_flush));
  endtask

  task automatic idle();
    bus.ifid_rs1     = '0;
    bus.ifid_rs2     = '0;
    bus.ifid_use_rs1 = 1'b0;
    bus.ifid_use_rs2 = 1'b0;
    bus.idex_memread = 1'b0;
    bus.idex_rd      = '0;
    bus.idex_halt    = 1'b0;
    bus.ex_redirect  = 1'b0;
    bus.dmem_busy    = 1'b0;
  endtask

  // Drive at negedge, then sample mid low phase
  task automatic step();
    @(negedge clk);
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic do_reset();
    step();
    idle();
    reset_n = 1'b0;
    settle();
    chk("reset forced outputs", 32'(outs()), 32'(O_RESET));
    exp_stall = 0;
    exp_flush = 0;
    step();
    reset_n = 1'b1;
    settle();
  endtask

  initial begin
    vecs[0]  = '{"idle",              0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 0, O_RUN,   0, 0};
    vecs[1]  = '{"load-use rs1",      1, 0, 5'd5, 5'd0, 1, 5'd5, 0, 0, O_LU,    1, 0};
    vecs[2]  = '{"after load-use",    1, 0, 5'd5, 5'd0, 0, 5'd5, 0, 0, O_RUN,   0, 0};
    vecs[3]  = '{"x0 no stall",       1, 0, 5'd0, 5'd0, 1, 5'd0, 0, 0, O_RUN,   0, 0};
    vecs[4]  = '{"unused rs2",        0, 0, 5'd0, 5'd7, 1, 5'd7, 0, 0, O_RUN,   0, 0};
    vecs[5]  = '{"load-use rs2",      0, 1, 5'd0, 5'd7, 1, 5'd7, 0, 0, O_LU,    1, 0};
    vecs[6]  = '{"redirect over lu",  1, 0, 5'd5, 5'd0, 1, 5'd5, 1, 0, O_REDIR, 0, 1};
    vecs[7]  = '{"busy over redir",   0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 1, O_BUSY,  0, 0};
    vecs[8]  = '{"redir after busy",  0, 0, 5'd0, 5'd0, 0, 5'd0, 1, 0, O_REDIR, 0, 1};
    vecs[9]  = '{"busy over lu",      1, 0, 5'd9, 5'd0, 1, 5'd9, 0, 1, O_BUSY,  0, 0};
    vecs[10] = '{"rd mismatch",       1, 1, 5'd4, 5'd2, 1, 5'd3, 0, 0, O_RUN,   0, 0};
    vecs[11] = '{"busy only",         0, 0, 5'd0, 5'd0, 0, 5'd0, 0, 1, O_BUSY,  0, 0};

    idle();
    reset_n = 1'b0;
    step();
    do_reset();
    chk("post-reset idle", 32'(outs()), 32'(O_RUN));
    chk_cnt("post-reset");

    // Table-driven RUN vectors
    for (int i = 0; i < 12; i++) begin
      step();
      bus.ifid_use_rs1 = vecs[i].use1;
      bus.ifid_use_rs2 = vecs[i].use2;
      bus.ifid_rs1     = vecs[i].rs1;
      bus.ifid_rs2     = vecs[i].rs2;
      bus.idex_memread = vecs[i].memread;
      bus.idex_rd      = vecs[i].rd;
      bus.ex_redirect  = vecs[i].redir;
      bus.dmem_busy    = vecs[i].busy;
      bus.idex_halt    = 1'b0;
      settle();
      chk(vecs[i].name, 32'(outs()), 32'(vecs[i].exp));
      chk_cnt(vecs[i].name);
      exp_stall += vecs[i].stall_inc;
      exp_flush += vecs[i].flush_inc;
    end
    step();
    idle();
    settle();
    chk_cnt("table end");

    // Halt drain, no busy: halted at N+3; redirect ignored while draining
    step(); bus.idex_halt = 1'b1; settle();
    chk("halt N", 32'(outs()), 32'(O_DRAIN));
    step(); idle(); settle();
    chk("drain N+1", 32'(outs()), 32'(O_DRAIN));
    step(); bus.ex_redirect = 1'b1; settle();
    chk("drain N+2 redir ignored", 32'(outs()), 32'(O_DRAIN));
    step(); idle(); settle();
    chk("halted N+3", 32'(outs()), 32'(O_HALTED));
    step(); bus.ex_redirect = 1'b1; bus.idex_memread = 1'b1; settle();
    chk("halted sticky", 32'(outs()), 32'(O_HALTED));
    chk_cnt("halted");

    do_reset();
    chk("rerun idle", 32'(outs()), 32'(O_RUN));
    chk_cnt("rerun");

    // Halt drain with busy during N+1: halted at N+4
    step(); bus.idex_halt = 1'b1; settle();
    chk("halt2 N", 32'(outs()), 32'(O_DRAIN));
    step(); idle(); bus.dmem_busy = 1'b1; settle();
    chk("drain2 N+1 busy", 32'(outs()), 32'(O_DRAINB));
    step(); idle(); settle();
    chk("drain2 N+2", 32'(outs()), 32'(O_DRAIN));
    step(); settle();
    chk("drain2 N+3", 32'(outs()), 32'(O_DRAIN));
    step(); settle();
    chk("halted2 N+4", 32'(outs()), 32'(O_HALTED));

    do_reset();

    // Build nonzero counts, then reset during DRAIN
    step();
    bus.ex_redirect = 1'b1;
    settle();
    chk("redir pre-drain", 32'(outs()), 32'(O_REDIR));
    exp_flush++;
    step(); idle(); settle();
    chk_cnt("pre-drain");
    step(); bus.idex_halt = 1'b1; settle();
    chk("halt3 N", 32'(outs()), 32'(O_DRAIN));
    step(); idle(); reset_n = 1'b0; settle();
    chk("reset in drain", 32'(outs()), 32'(O_RESET));
    exp_stall = 0;
    exp_flush = 0;
    step(); reset_n = 1'b1; settle();
    chk("after drain reset", 32'(outs()), 32'(O_RUN));
    chk_cnt("after drain reset");
    step(); settle();
    chk("run continues", 32'(outs()), 32'(O_RUN));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Backward-flowing control for the 5-stage pipeline. It consumes fields captured in the IF/ID, ID/EX and EX/MEM buffer registers.
- It produces enables and flushes for the PC and for buffers A–D.
- It detects load-use hazards and applies taken-branch/jump redirects, memory-busy freezes, and HALT drain.
- It sits beside the datapath; all outputs are decoded from current inputs plus internal state.

Parameters:
- REG_AW, 5, register-address width.
- DRAIN_CYCLES, 2, cycles after HALT reaches EX before the core is declared halted (covers MEM, WB).

Ports:
- clk  in  1  core clock
- reset_n  in  1  synchronous active-low reset
- ifid_rs1  in  REG_AW  rs1 field of instruction in IF/ID
- ifid_rs2  in  REG_AW  rs2 field of instruction in IF/ID
- ifid_use_rs1  in  1  IF/ID instruction reads rs1
- ifid_use_rs2  in  1  IF/ID instruction reads rs2
- idex_memread  in  1  ID/EX MemRead
- idex_rd  in  REG_AW  ID/EX rd
- idex_halt  in  1  ID/EX Halt
- ex_redirect  in  1  branch taken or Jump/JALR resolved in EX this cycle
- dmem_busy  in  1  data memory not ready; freeze pipeline
- pc_en  out  1  PC update enable
- ifid_en  out  1  buffer A load enable
- ifid_flush  out  1  buffer A load NOP/bubble
- idex_en  out  1  buffer B load enable
- idex_flush  out  1  buffer B load bubble (all control bits 0)
- exmem_en  out  1  buffer C load enable
- memwb_en  out  1  buffer D load enable
- halted  out  1  core halted
- stall_cycles  out  32  load-use stall count (optional)
- flush_cycles  out  32  redirect flush count (optional)

Behaviour:
- States: RUN, DRAIN, HALTED. Drain counter dcnt is $clog2(DRAIN_CYCLES+1) bits.
- Reset (reset_n=0 at posedge): state=RUN, dcnt=0, counters=0.
  - While reset_n=0, outputs are forced: pc_en=ifid_en=idex_en=exmem_en=memwb_en=0, ifid_flush=idex_flush=1, halted=0.
- Hazard term: load_use = idex_memread & (idex_rd!=0) & ((ifid_use_rs1 & idex_rd==ifid_rs1) | (ifid_use_rs2 & idex_rd==ifid_rs2)).
- RUN output priority, highest first:
  1. dmem_busy: all enables 0, no flushes. State and counters unchanged.
  2. ex_redirect: pc_en=1, all enables 1, ifid_flush=1, idex_flush=1. load_use and idex_halt are ignored because the younger instructions are killed.
  3. idex_halt: next state DRAIN, dcnt=DRAIN_CYCLES. This cycle pc_en=0, ifid_flush=1, idex_flush=1, exmem_en=memwb_en=1.
  4. load_use: pc_en=0, ifid_en=0, idex_flush=1, exmem_en=memwb_en=1. Exactly one bubble per load-use pair; the next cycle re-evaluates.
  5. otherwise: all enables 1, no flushes.
- Flush semantics: flush overrides en (a flushed buffer loads a bubble even if en=0). When ifid_flush=1 or idex_flush=1, the corresponding en is driven 1.
- DRAIN:
  - pc_en=0, ifid_flush=idex_flush=1.
  - exmem_en=memwb_en = ~dmem_busy.
  - dcnt decrements only when dmem_busy=0. At dcnt==1 with dmem_busy=0, next state is HALTED.
  - ex_redirect is ignored.
- HALTED: all enables 0, flushes 0, halted=1. Exit only by reset.
- Reset mid-DRAIN: returns to RUN immediately; no pending state survives.
- Latency: all hazard responses are same-cycle combinational. halted rises DRAIN_CYCLES+1 non-busy cycles after idex_halt is first seen.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined:
  - stall_cycles increments each RUN cycle where load_use is the selected action.
  - flush_cycles increments each RUN cycle where ex_redirect is the selected action.
  - Both are 32-bit, saturate at 0xFFFFFFFF, and clear on reset.
- Undefined: both outputs are tied to 0 and no counter flops are built.

Test Plan:
- Load-use: idex_memread=1, idex_rd=5, ifid_rs1=5, ifid_use_rs1=1 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1, exmem_en=1. Next cycle with idex_memread=0 -> all enables 1. stall_cycles=1 with macro.
- x0 / unused operand: idex_rd=0 with matching rs1, then idex_rd=7 with ifid_rs2=7 and ifid_use_rs2=0 -> no stall in either case.
- Redirect vs load_use: ex_redirect=1 and load_use true together -> pc_en=1, ifid_flush=1, idex_flush=1; flush_cycles=1, stall_cycles unchanged.
- Halt drain with DRAIN_CYCLES=2: idex_halt=1 at cycle N.
  - Without busy -> pc_en=0 from N, halted=1 at N+3.
  - With dmem_busy=1 during N+1 -> halted=1 at N+4.
- Busy freeze: dmem_busy=1 together with ex_redirect=1 -> all enables 0, no flushes. When busy drops -> redirect flush is applied.
- Reset in DRAIN: reset_n=0 for one cycle at N+1 -> next cycle state RUN, halted=0, all enables 1 with idle inputs, counters 0.
